// File: rtl/seq_arith_unit_pkg.sv
// seq_arith_unit_pkg: alu_defs opcode constants and the sequential arith unit state type
// Shared by seq_arith_unit and its testbench; no ports.
package seq_arith_unit_pkg;
    localparam logic [2:0] ARITH_ADD = 3'd0;
    localparam logic [2:0] ARITH_SUB = 3'd1;
    localparam logic [2:0] ARITH_MOD = 3'd2;
    localparam logic [2:0] ARITH_EXP = 3'd3;
    localparam logic [2:0] MOV_      = 3'd4;
    typedef enum logic [2:0] {IDLE, RED, MUL, UPD, DONE} arith_state_e;
endpackage

// File: rtl/seq_arith_unit_mod_mul.sv
// mod_mul: iterative MSB-first interleaved modular multiplier, r = x*y mod m after N steps
// Ports: clk_i, rst_ni (async active-low), load_i (capture x_i/y_i, clear r),
//        x_i, y_i (both < m_i), m_i (held stable while stepping), r_o (running remainder).
// Steps every cycle it is not loading; the owner reads r_o exactly N cycles after load.
module mod_mul #(
    parameter int N = 8
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         load_i,
    input  logic [N-1:0] x_i,
    input  logic [N-1:0] y_i,
    input  logic [N-1:0] m_i,
    output logic [N-1:0] r_o
);
    logic [N-1:0] x_q, x_d, y_q, y_d, r_q, r_d;
    logic [N+1:0] mw, t, t1;
    always_comb begin
        mw  = {2'b00, m_i};
        // 2r + y < 3m, so two conditional subtractions bring it back below m
        t   = {1'b0, r_q, 1'b0} + (x_q[N-1] ? {2'b00, y_q} : '0);
        t1  = t >= mw ? t - mw : t;
        r_d = load_i ? '0 : N'(t1 >= mw ? t1 - mw : t1);
        x_d = load_i ? x_i : x_q << 1;
        y_d = load_i ? y_i : y_q;
    end
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            x_q <= '0;
            y_q <= '0;
            r_q <= '0;
        end else begin
            x_q <= x_d;
            y_q <= y_d;
            r_q <= r_d;
        end
    end
    assign r_o = r_q;
endmodule

// File: rtl/seq_arith_unit.sv
// seq_arith_unit: multi-cycle ADD/SUB/MOV/MOD/EXP unit with start/busy/done handshake
// Ports: clk_i, rst_ni (async active-low), start_i, opcode_i[2:0], a_i/b_i/m_i[N-1:0],
//        busy_o, done_o (one-cycle pulse), result_o[N-1:0], overflow_o, cout_o, div_zero_o.
// Option: define SEQ_ARITH_EXP_EARLY_EXIT_EN to end EXP once the remaining exponent is zero.
module seq_arith_unit
    import seq_arith_unit_pkg::*;
#(
    parameter int N = 8
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         start_i,
    input  logic [2:0]   opcode_i,
    input  logic [N-1:0] a_i,
    input  logic [N-1:0] b_i,
    input  logic [N-1:0] m_i,
    output logic         busy_o,
    output logic         done_o,
    output logic [N-1:0] result_o,
    output logic         overflow_o,
    output logic         cout_o,
    output logic         div_zero_o
);
    localparam int CW = $clog2(N + 1);
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    arith_state_e state_q, state_d;
    logic [N-1:0] a_q, a_d, base_q, base_d, acc_q, acc_d, exp_q, exp_d, m_q, m_d, res_q, res_d;
    logic [2:0] op_q, op_d;
    logic [CW-1:0] cnt_q, cnt_d, it_q, it_d;
    logic ovf_q, ovf_d, cout_q, cout_d, dz_q, dz_d;
    logic [N:0] sum, dif, sh;
    logic [N-1:0] red_r, r_ab, r_bb, upd_acc;
    logic is_add, is_sub, is_me, multi, cnt_last, upd_last, ld;

    assign is_add   = opcode_i == ARITH_ADD;
    assign is_sub   = opcode_i == ARITH_SUB;
    assign is_me    = opcode_i == ARITH_MOD || opcode_i == ARITH_EXP;
    assign multi    = is_me && m_i != '0;
    assign sum      = {1'b0, a_i} + {1'b0, b_i};
    assign dif      = {1'b0, a_i} - {1'b0, b_i};
    // restoring reduction: remainder lives in base_q, dividend bits shift out of a_q MSB-first
    assign sh       = {base_q, a_q[N-1]};
    assign red_r    = N'(sh >= {1'b0, m_q} ? sh - {1'b0, m_q} : sh);
    assign cnt_last = cnt_q == LAST;
    assign upd_acc  = exp_q[0] ? r_ab : acc_q;
`ifdef SEQ_ARITH_EXP_EARLY_EXIT_EN
    assign upd_last = it_q == LAST || (exp_q >> 1) == '0;
`else
    assign upd_last = it_q == LAST;
`endif

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) state_q <= IDLE;
        else state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = start_i ? (multi ? RED : DONE) : IDLE;
            RED:     state_d = cnt_last ? (op_q == ARITH_MOD ? DONE : MUL) : RED;
            MUL:     state_d = cnt_last ? UPD : MUL;
            UPD:     state_d = upd_last ? DONE : MUL;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy_o = state_q == RED || state_q == MUL || state_q == UPD;
        done_o = state_q == DONE;
    end

    always_comb begin
        a_d = a_q;
        base_d = base_q;
        acc_d = acc_q;
        exp_d = exp_q;
        m_d = m_q;
        op_d = op_q;
        cnt_d = cnt_q;
        it_d = it_q;
        res_d = res_q;
        ovf_d = ovf_q;
        cout_d = cout_q;
        dz_d = dz_q;
        ld = 1'b0;
        case (state_q)
            IDLE: if (start_i) begin
                op_d = opcode_i;
                a_d = a_i;
                exp_d = b_i;
                m_d = m_i;
                base_d = '0;
                cnt_d = '0;
                it_d = '0;
                if (!multi) begin
                    res_d = is_add ? sum[N-1:0] : is_sub ? dif[N-1:0] : opcode_i == MOV_ ? b_i :
                            opcode_i == ARITH_MOD ? a_i : '0;
                    ovf_d = is_add ? ~(a_i[N-1] ^ b_i[N-1]) & (sum[N-1] ^ a_i[N-1]) :
                            is_sub ? (a_i[N-1] ^ b_i[N-1]) & (dif[N-1] ^ a_i[N-1]) : 1'b0;
                    cout_d = is_add ? sum[N] : is_sub ? dif[N] : 1'b0;
                    dz_d = is_me;
                end
            end
            RED: begin
                a_d = a_q << 1;
                base_d = red_r;
                cnt_d = cnt_last ? '0 : cnt_q + 1'b1;
                if (cnt_last && op_q == ARITH_MOD) {res_d, ovf_d, cout_d, dz_d} = {red_r, 3'b000};
                if (cnt_last && op_q != ARITH_MOD) begin
                    acc_d = m_q == N'(1) ? '0 : N'(1);
                    ld = 1'b1;
                end
            end
            MUL: cnt_d = cnt_last ? '0 : cnt_q + 1'b1;
            UPD: begin
                acc_d = upd_acc;
                base_d = r_bb;
                exp_d = exp_q >> 1;
                it_d = it_q + 1'b1;
                ld = 1'b1;
                if (upd_last) {res_d, ovf_d, cout_d, dz_d} = {upd_acc, 3'b000};
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            a_q <= '0;
            base_q <= '0;
            acc_q <= '0;
            exp_q <= '0;
            m_q <= '0;
            op_q <= '0;
            cnt_q <= '0;
            it_q <= '0;
            res_q <= '0;
            ovf_q <= 1'b0;
            cout_q <= 1'b0;
            dz_q <= 1'b0;
        end else begin
            a_q <= a_d;
            base_q <= base_d;
            acc_q <= acc_d;
            exp_q <= exp_d;
            m_q <= m_d;
            op_q <= op_d;
            cnt_q <= cnt_d;
            it_q <= it_d;
            res_q <= res_d;
            ovf_q <= ovf_d;
            cout_q <= cout_d;
            dz_q <= dz_d;
        end
    end

    // both products are loaded with the values acc/base take on this edge
    mod_mul #(.N(N)) u_mul_ab (
        .clk_i(clk_i), .rst_ni(rst_ni), .load_i(ld),
        .x_i(acc_d), .y_i(base_d), .m_i(m_q), .r_o(r_ab)
    );
    mod_mul #(.N(N)) u_mul_bb (
        .clk_i(clk_i), .rst_ni(rst_ni), .load_i(ld),
        .x_i(base_d), .y_i(base_d), .m_i(m_q), .r_o(r_bb)
    );

    assign result_o = res_q;
    assign overflow_o = ovf_q;
    assign cout_o = cout_q;
    assign div_zero_o = dz_q;
endmodule

// File: tb/tb_seq_arith_unit.sv
// tb_seq_arith_unit: directed vectors against a behavioural model of seq_arith_unit
module tb_seq_arith_unit;
    import seq_arith_unit_pkg::*;
    localparam int N = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    logic start = 1'b0;
    logic [2:0] opcode = '0;
    logic [N-1:0] a = '0, b = '0, m = '0;
    logic busy, done, ovf, cout, dz;
    logic [N-1:0] res;

    int errors = 0, checks = 0;
    bit armed = 0;
    int k = 0, lat = 0;
    int e_res, e_o, e_c, e_z;
    int h_res = 0, h_o = 0, h_c = 0, h_z = 0;

    typedef struct {
        logic [2:0] op;
        int a, b, m, res, o, c, z, lat, late;
    } vec_t;
    vec_t vt[14];

    seq_arith_unit #(.N(N)) dut (
        .clk_i(clk), .rst_ni(rst_n), .start_i(start), .opcode_i(opcode),
        .a_i(a), .b_i(b), .m_i(m), .busy_o(busy), .done_o(done),
        .result_o(res), .overflow_o(ovf), .cout_o(cout), .div_zero_o(dz)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, expv, $time);
        end
    endtask

    function automatic int sgn(input int v);
        return v >= 128 ? v - 256 : v;
    endfunction

    task automatic model(input logic [2:0] op, input int va, vb, vm,
                         output int r, o, c, z, l);
        int s, kk;
        r = 0; o = 0; c = 0; z = 0; l = 1;
        if (op == ARITH_ADD) begin
            s = va + vb;
            r = s % 256;
            c = s / 256;
            s = sgn(va) + sgn(vb);
            o = (s > 127 || s < -128) ? 1 : 0;
        end else if (op == ARITH_SUB) begin
            r = (va - vb + 256) % 256;
            c = va < vb ? 1 : 0;
            s = sgn(va) - sgn(vb);
            o = (s > 127 || s < -128) ? 1 : 0;
        end else if (op == MOV_) begin
            r = vb;
        end else if (op == ARITH_MOD) begin
            if (vm == 0) begin r = va; z = 1; end
            else begin r = va % vm; l = N + 1; end
        end else if (op == ARITH_EXP) begin
            if (vm == 0) z = 1;
            else begin
                r = 1 % vm;
                for (int j = 0; j < vb; j++) r = (r * va) % vm;
                kk = N;
`ifdef SEQ_ARITH_EXP_EARLY_EXIT_EN
                kk = 1;
                for (int j = 0; j < N; j++) if ((vb >> j) & 1) kk = j + 1;
`endif
                l = N + kk * (N + 1) + 1;
            end
        end
    endtask

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (armed) begin
                k++;
                chk("done_pulse", done, k == lat);
                chk("busy", busy, k < lat);
                if (k == lat) begin
                    chk("result", res, e_res);
                    chk("overflow", ovf, e_o);
                    chk("cout", cout, e_c);
                    chk("div_zero", dz, e_z);
                    h_res = e_res; h_o = e_o; h_c = e_c; h_z = e_z;
                    armed = 0;
                end
            end else begin
                chk("idle_done", done, 0);
                chk("idle_busy", busy, 0);
                chk("held_result", res, h_res);
                chk("held_flags", {ovf, cout, dz}, {h_o[0], h_c[0], h_z[0]});
            end
        end
    end

    task automatic launch(input logic [2:0] op, input int va, vb, vm);
        int l;
        model(op, va, vb, vm, e_res, e_o, e_c, e_z, l);
        @(negedge clk);
        opcode = op; a = N'(va); b = N'(vb); m = N'(vm);
        start = 1'b1;
        lat = l; k = 0; armed = 1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic run(input int i, input bit disturb);
        int r, o, c, z, l;
        model(vt[i].op, vt[i].a, vt[i].b, vt[i].m, r, o, c, z, l);
        chk($sformatf("model_res[%0d]", i), r, vt[i].res);
        chk($sformatf("model_flags[%0d]", i), {o[0], c[0], z[0]}, {vt[i].o[0], vt[i].c[0], vt[i].z[0]});
`ifdef SEQ_ARITH_EXP_EARLY_EXIT_EN
        chk($sformatf("model_lat[%0d]", i), l, vt[i].late);
`else
        chk($sformatf("model_lat[%0d]", i), l, vt[i].lat);
`endif
        launch(vt[i].op, vt[i].a, vt[i].b, vt[i].m);
        if (disturb) begin
            repeat (3) @(negedge clk);
            start = 1'b1; opcode = ARITH_ADD; a = 8'h01; b = 8'h01; m = 8'h00;
            @(negedge clk);
            start = 1'b0; a = 8'hAA; b = 8'h55; m = 8'h03;
        end
        for (int cy = 0; cy < 300 && armed; cy++) @(negedge clk);
        if (armed) begin
            errors++;
            checks++;
            $display("FAIL timeout[%0d]: no done_o within 300 cycles, expected at %0d", i, lat);
            armed = 0;
        end
    endtask

    initial begin
        vt[0]  = '{ARITH_ADD, 8'h7F, 8'h01, 0,   8'h80, 1, 0, 0, 1, 1};
        vt[1]  = '{ARITH_SUB, 8'h00, 8'h01, 0,   8'hFF, 0, 1, 0, 1, 1};
        vt[2]  = '{MOV_,      8'h00, 8'h5A, 0,   8'h5A, 0, 0, 0, 1, 1};
        vt[3]  = '{ARITH_MOD, 200,   0,     7,   4,     0, 0, 0, 9, 9};
        vt[4]  = '{ARITH_MOD, 9,     0,     0,   9,     0, 0, 1, 1, 1};
        vt[5]  = '{ARITH_EXP, 9,     7,     143, 48,    0, 0, 0, 81, 36};
        vt[6]  = '{ARITH_EXP, 5,     0,     1,   0,     0, 0, 0, 81, 18};
        vt[7]  = '{ARITH_ADD, 8'h80, 8'h80, 0,   8'h00, 1, 1, 0, 1, 1};
        vt[8]  = '{ARITH_SUB, 8'h80, 8'h01, 0,   8'h7F, 1, 0, 0, 1, 1};
        vt[9]  = '{3'd7,      8'hFF, 8'hFF, 5,   0,     0, 0, 0, 1, 1};
        vt[10] = '{ARITH_EXP, 3,     200,   0,   0,     0, 0, 1, 1, 1};
        vt[11] = '{ARITH_EXP, 2,     10,    255, 4,     0, 0, 0, 81, 45};
        vt[12] = '{ARITH_MOD, 255,   0,     255, 0,     0, 0, 0, 9, 9};
        vt[13] = '{ARITH_EXP, 255,   255,   254, 1,     0, 0, 0, 81, 81};
        #1 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        chk("reset_outputs", {busy, done, ovf, cout, dz}, 5'b0);
        chk("reset_result", res, 0);
        rst_n = 1'b1;
        for (int i = 0; i < 14; i++) run(i, 1'b0);
        run(5, 1'b1);
        run(3, 1'b1);
        launch(ARITH_EXP, 9, 7, 143);
        repeat (20) @(negedge clk);
        rst_n = 1'b0;
        armed = 0;
        h_res = 0; h_o = 0; h_c = 0; h_z = 0;
        #1;
        chk("abort_outputs", {busy, done, ovf, cout, dz}, 5'b0);
        chk("abort_result", res, 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        run(5, 1'b0);
        run(0, 1'b0);
        repeat (2) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/seq_arith_unit.md
Name: seq_arith_unit

Overview:
Multi-cycle, parametrised successor of the combinational arith unit for the RSA pipeline CPU.
- Keeps single-cycle ADD/SUB/MOV.
- Implements the previously stubbed ARITH_MOD (a mod m) and ARITH_EXP (a^b mod m).
- Uses a start/busy/done handshake with a fixed, opcode-dependent latency.
- Sits in the EX stage; the pipeline stalls on busy_o.

Parameters:
N, 8, operand/result width in bits (N ≥ 2)

Ports:
clk_i  in  1  clock; all state updates on rising edge
rst_ni  in  1  reset, asynchronous, active-low
start_i  in  1  request; sampled only in IDLE
opcode_i  in  3  alu_defs opcode (ARITH_ADD, ARITH_SUB, ARITH_MOD, ARITH_EXP, MOV_)
a_i  in  N  operand A / base
b_i  in  N  operand B / exponent
m_i  in  N  modulus (MOD, EXP only)
busy_o  out  1  operation in progress
done_o  out  1  one-cycle pulse; result/flags valid from this cycle
result_o  out  N  registered result; held until next done_o
overflow_o  out  1  signed overflow (ADD/SUB only)
cout_o  out  1  bit N of N+1-bit ADD/SUB result
div_zero_o  out  1  m_i == 0 on MOD/EXP

Behaviour:
- Reset (rst_ni low, any time, including mid-operation): state IDLE; busy_o, done_o, result_o, overflow_o, cout_o, div_zero_o all 0; no done_o for the aborted operation.
- Operands, opcode and modulus are captured on the accepting edge; later input changes are ignored.
- start_i while busy_o=1 or in DONE is ignored.
- Latency L = edges from accepting edge to the cycle with done_o=1:
  - ADD/SUB/MOV/undefined opcode: L=1
  - MOD: L=N+1
  - EXP: L=N+N(N+1)+1
  - m_i==0 on MOD/EXP: L=1
- busy_o is 1 from the cycle after acceptance until done_o; it is 0 in the done_o cycle.
- FSM states: IDLE, RED, MUL, UPD, DONE.
  - IDLE→DONE for single-cycle ops or m==0.
  - IDLE→RED for MOD/EXP.
  - RED: N cycles, restoring reduction (one bit per cycle, N+1-bit remainder), producing a mod m.
    - MOD: RED→DONE.
    - EXP: RED→MUL, with base = a mod m, acc = (m==1 ? 0 : 1), exponent register = b.
  - MUL: N cycles; two mod_mul instances run in parallel (acc·base, base·base).
  - UPD: 1 cycle. If exponent LSB=1 then acc ← acc·base mod m. Always base ← base² mod m; exponent >> 1; bit counter +1. Go to MUL while counter < N, else DONE.
  - DONE: 1 cycle, done_o=1, result/flags registers updated, then IDLE.
- Arithmetic and flags:
  - ADD: result = a+b, overflow = ~(a[N-1]^b[N-1]) & (r[N-1]^a[N-1]).
  - SUB: result = a−b, overflow = (a[N-1]^b[N-1]) & (r[N-1]^a[N-1]).
  - cout = r[N] for both.
  - MOV: result = b.
  - MOD/EXP: unsigned; overflow_o = cout_o = 0.
  - Undefined opcode: result 0, all flags 0.
- m==0: div_zero_o=1. MOD result = a; EXP result = 0.
- div_zero_o is 0 for every other completion.

Optional Feature:
SEQ_ARITH_EXP_EARLY_EXIT_EN
- Defined: in UPD, if the shifted exponent is zero, go to DONE immediately. EXP latency becomes N+k(N+1)+1, with k = index of the MSB set in b plus 1, or k=1 when b=0. Results are unchanged.
- Undefined: fixed latency as above.

Decomposition:
- alu_defs package: existing opcode constants plus new arith_state_e (IDLE, RED, MUL, UPD, DONE).
- Sub-module mod_mul:
  - Iterative interleaved modular multiplier, MSB-first.
  - Per cycle: r ← 2r + x_bit·y, then subtract m at most twice, in N+2-bit width.
  - Ports: clk/reset, load, x, y, m; result r < m after N cycles.
  - Precondition: x, y < m.
  - Instantiated twice.

Test Plan:
- N=8, ADD a=0x7F b=0x01 → done_o 1 edge later, result 0x80, overflow_o 1, cout_o 0.
- SUB a=0x00 b=0x01 → result 0xFF, overflow_o 0, cout_o 1; MOV b=0x5A → 0x5A.
- MOD a=200 m=7 → result 4 at 9 edges; MOD a=9 m=0 → result 9, div_zero_o 1, done at 1 edge.
- EXP a=9 b=7 m=143 → result 48 at 81 edges (early-exit build: 8+3·9+1=36); EXP a=5 b=0 m=1 → 0.
- start_i pulsed with new operands while busy → ignored, first result unaffected.
- rst_ni low mid-EXP → all outputs 0 immediately, no done_o; next EXP correct.
